uart_tx: RTL and testbench

Serial transmitter for the UART path. It takes a parallel byte on a one-cycle start strobe and shifts it out LSB-first on `tx` as one frame: start bit, data bits, optional parity bit, then stop bit(s). Bit timing comes from the external baud-rate tick generator: `s_tick` pulses at 16x the baud rate, and every bit except the stop bit lasts 16 ticks. The block sits between the host-side TX FIFO/control logic and the serial pin, mirroring the receiver.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_tx_if.sv | 9 +
 rtl/uart_tx.sv | 95 +++++++++
 tb/tb_uart_tx.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART states, parity modes and oversampling ratio
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD = 2;
  localparam int OVERSAMPLE = 16;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: host-side handshake between TX control logic and the transmitter
interface uart_tx_if #(parameter int DBIT = 8);
  logic tx_start;
  logic [DBIT-1:0] din;
  logic busy;
  logic tx_done_tick;
  modport master (output tx_start, din, input busy, tx_done_tick);
  modport slave (input tx_start, din, output busy, tx_done_tick);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: LSB-first serial transmitter with optional parity, paced by a 16x baud tick
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY = PAR_NONE
) (
  input  logic clk,
  input  logic reset,
  input  logic s_tick,
  uart_tx_if.slave bus,
  output logic tx
);
  localparam int TW = $clog2(SB_TICK);
  localparam logic ODD = (PARITY == PAR_ODD);
  if (DBIT < 5 || DBIT > 8 || !(SB_TICK == 16 || SB_TICK == 24 || SB_TICK == 32) ||
      PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_param
    $error("uart_tx: illegal parameter value");
  end
  tx_state_t state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [DBIT-1:0] sh_q, sh_d;
  logic par_q, par_d, tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic bit_end;
  assign bit_end = s_tick && tick_q == TW'(OVERSAMPLE - 1);
  always_comb begin
    state_d = state_q;
    tick_d = tick_q;
    bit_d = bit_q;
    sh_d = sh_q;
    par_d = par_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.tx_start) begin
        sh_d = bus.din;
        tick_d = '0;
        par_d = 1'b0;
        state_d = START;
      end
      START: if (bit_end) begin
        tick_d = '0;
        bit_d = '0;
        state_d = DATA;
      end else if (s_tick) tick_d = tick_q + TW'(1);
      DATA: if (bit_end) begin
        tick_d = '0;
        sh_d = sh_q >> 1;
        par_d = par_q ^ sh_q[0];
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'(DBIT - 1)) state_d = (PARITY != PAR_NONE) ? PAR : STOP;
      end else if (s_tick) tick_d = tick_q + TW'(1);
      PAR: if (bit_end) begin
        tick_d = '0;
        state_d = STOP;
      end else if (s_tick) tick_d = tick_q + TW'(1);
      STOP: if (s_tick && tick_q == TW'(SB_TICK - 1)) begin
        tick_d = '0;
        done_d = 1'b1;
        state_d = IDLE;
      end else if (s_tick) tick_d = tick_q + TW'(1);
      default: state_d = IDLE;
    endcase
    // Line level follows the next state so tx stays a pure flop output
    tx_d = (state_d == START) ? 1'b0 :
           (state_d == DATA)  ? sh_d[0] :
           (state_d == PAR)   ? par_d ^ ODD : 1'b1;
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      par_q <= par_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign tx = tx_q;
  assign bus.busy = busy_q;
  assign bus.tx_done_tick = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame checks for uart_tx across parity and stop-bit variants
module tb_uart_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_tick = 1'b0;
  logic [1:0] ph = 2'd0;
  logic [3:0] start = 4'd0;
  logic [7:0] din = 8'd0;
  logic [3:0] tx, busy, done;
  int n_assert = 0;
  int n_fail = 0;
  int n_done = 0;

  always #5 clk = ~clk;
  always @(negedge clk) begin
    ph <= ph + 2'd1;
    s_tick <= (ph == 2'd3);
  end
  always @(negedge clk) if (done[0]) n_done++;

  uart_tx_if #(.DBIT(8)) if0 ();
  uart_tx_if #(.DBIT(8)) if1 ();
  uart_tx_if #(.DBIT(8)) if2 ();
  uart_tx_if #(.DBIT(7)) if3 ();
  assign if0.tx_start = start[0];
  assign if1.tx_start = start[1];
  assign if2.tx_start = start[2];
  assign if3.tx_start = start[3];
  assign if0.din = din;
  assign if1.din = din;
  assign if2.din = din;
  assign if3.din = din[6:0];
  assign busy = {if3.busy, if2.busy, if1.busy, if0.busy};
  assign done = {if3.tx_done_tick, if2.tx_done_tick, if1.tx_done_tick, if0.tx_done_tick};

  uart_tx u0 (.clk(clk), .reset(reset), .s_tick(s_tick), .bus(if0.slave), .tx(tx[0]));
  uart_tx #(.PARITY(1)) u1 (.clk(clk), .reset(reset), .s_tick(s_tick), .bus(if1.slave), .tx(tx[1]));
  uart_tx #(.PARITY(2)) u2 (.clk(clk), .reset(reset), .s_tick(s_tick), .bus(if2.slave), .tx(tx[2]));
  uart_tx #(.DBIT(7), .SB_TICK(32)) u3 (.clk(clk), .reset(reset), .s_tick(s_tick), .bus(if3.slave), .tx(tx[3]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic send(input int s, input logic [7:0] d);
    start[s] = 1'b1;
    din = d;
    @(posedge clk) #1;
    chk("accept_tx_low", tx[s], 1'b0);
    chk("accept_busy", busy[s], 1'b1);
    start[s] = 1'b0;
    din = ~d;
  endtask

  // exp holds line levels of start, data and parity bits in order, bit 0 first
  task automatic frame(input int s, input logic [7:0] d, input logic [11:0] exp,
                       input int nbits, input int stop_ticks, input string tag);
    send(s, d);
    for (int i = 0; i < nbits; i++) begin
      tick_edges(i == 0 ? 8 : 16);
      chk($sformatf("%s_bit%0d", tag, i), tx[s], exp[i]);
    end
    tick_edges(16);
    chk({tag, "_stop_mid"}, tx[s], 1'b1);
    tick_edges(stop_ticks - 9);
    chk({tag, "_stop_late"}, tx[s], 1'b1);
    chk({tag, "_no_early_done"}, done[s], 1'b0);
    chk({tag, "_busy_late"}, busy[s], 1'b1);
    tick_edges(1);
    chk({tag, "_done"}, done[s], 1'b1);
    chk({tag, "_idle_busy"}, busy[s], 1'b0);
    @(posedge clk) #1;
    chk({tag, "_done_pulse"}, done[s], 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      chk("reset_tx", tx[s], 1'b1);
      chk("reset_busy", busy[s], 1'b0);
      chk("reset_done", done[s], 1'b0);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    frame(0, 8'h55, 12'h0AA, 9, 16, "8n1_55");
    frame(1, 8'h07, 12'b0010_0000_1110, 10, 16, "even_07");
    frame(2, 8'h07, 12'b0000_0000_1110, 10, 16, "odd_07");
    frame(3, 8'h5A, 12'h0B4, 8, 32, "7n2_5a");

    n_done = 0;
    send(0, 8'h00);
    tick_edges(40);
    chk("mid_bit1", tx[0], 1'b0);
    start[0] = 1'b1;
    din = 8'hFF;
    @(posedge clk) #1;
    start[0] = 1'b0;
    for (int k = 2; k < 8; k++) begin
      tick_edges(16);
      chk($sformatf("ignore_bit%0d", k), tx[0], 1'b0);
    end
    tick_edges(56);
    chk("ignore_one_done", (n_done == 1), 1'b1);
    chk("ignore_not_queued", busy[0], 1'b0);

    start[0] = 1'b1;
    din = 8'hA5;
    @(posedge clk) #1;
    tick_edges(159);
    chk("b2b_first_no_done", done[0], 1'b0);
    tick_edges(1);
    chk("b2b_first_done", done[0], 1'b1);
    chk("b2b_gap_tx", tx[0], 1'b1);
    @(posedge clk) #1;
    chk("b2b_second_start", tx[0], 1'b0);
    chk("b2b_second_busy", busy[0], 1'b1);
    start[0] = 1'b0;
    tick_edges(24);
    chk("b2b_second_d0", tx[0], 1'b1);
    tick_edges(135);
    chk("b2b_second_no_done", done[0], 1'b0);
    tick_edges(1);
    chk("b2b_second_done", done[0], 1'b1);

    send(0, 8'h00);
    tick_edges(70);
    reset = 1'b1;
    @(posedge clk) #1;
    chk("reset_mid_tx", tx[0], 1'b1);
    chk("reset_mid_busy", busy[0], 1'b0);
    reset = 1'b0;
    n_done = 0;
    tick_edges(120);
    chk("reset_mid_no_done", (n_done == 0), 1'b1);
    chk("reset_mid_idle_tx", tx[0], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
